// File: rtl/chunked_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle adder/subtractor. It adds CHUNK bits per clock, LSB chunk first,
// and finishes a WIDTH-bit add in NCH = WIDTH/CHUNK cycles. WIDTH must be an
// integer multiple of CHUNK.
//
// Handshake (valid/ready, both sides): a transfer happens on a rising edge
// where valid and ready are both 1. The producer holds its data stable while
// valid=1 and ready=0. in_ready is 1 only in IDLE. out_valid is 1 only in
// DONE. Results do not queue.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE)
//   A, B       operands (unsigned or two's complement)
//   CIN        carry-in, ignored when SUB=1
//   SUB        0: S = A+B+CIN, 1: S = A-B
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   S          sum/difference, modulo 2^WIDTH
//   C          carry-out of MSB (SUB=1: 1 = no borrow)
//   V          signed overflow
//   dbg_state  FSM state for observation: 0 = IDLE, 1 = BUSY, 2 = DONE
// -----------------------------------------------------------------------------
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic [1:0]       dbg_state
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtraction
  logic [WIDTH-1:0] w_q;      // working sum, filled chunk by chunk
  logic [WIDTH-1:0] s_q;      // visible result, updated only when entering DONE
  logic             carry_q;
  logic             c_q;
  logic             v_q;
  logic [IDXW-1:0]  idx_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] w_next;
  logic             v_next;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_chunk = (state_q == BUSY) && (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Chunk datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];
    csum    = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
    w_next  = w_q;
    w_next[int'(idx_q)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    // The carry into the MSB equals a_msb ^ b_msb ^ s_msb. XOR that with the
    // carry out of the MSB to get signed overflow. This works for any CHUNK,
    // including CHUNK=1.
    v_next  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      if (accept) begin
        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
        a_q     <= A;
        b_q     <= B ^ {WIDTH{SUB}};
        carry_q <= SUB | CIN;
        idx_q   <= '0;
      end else if (state_q == BUSY) begin
        w_q     <= w_next;
        carry_q <= csum[CHUNK];
        if (last_chunk) begin
          idx_q <= '0;
          s_q   <= w_next;
          c_q   <= csum[CHUNK];
          v_q   <= v_next;
        end else begin
          idx_q <= idx_q + IDXW'(1);
        end
      end
    end
  end

  assign S = s_q;
  assign C = c_q;
  assign V = v_q;

endmodule

// File: tb/tb_chunked_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_chunked_adder
//
// Four chunked_adder instances (CHUNK = 1, 4, 8, 16; WIDTH = 16) share one set
// of inputs. Expected results come from a plain-integer reference model and
// from a table of known vectors. Hand-written sequences cover backpressure and
// reset during BUSY.
// -----------------------------------------------------------------------------
module tb_chunked_adder;

  localparam int W  = 16;
  localparam int NI = 4;

  function automatic int chunk_of(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int nch_of(input int g);
    return W / chunk_of(g);
  endfunction

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          cin_in;
  logic          sub_in;

  logic [NI-1:0] in_ready_w;
  logic [NI-1:0] out_valid_w;
  logic [NI-1:0] c_w;
  logic [NI-1:0] v_w;
  logic [W-1:0]  s_w   [NI];
  logic [1:0]    dbg_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chunked_adder #(.WIDTH(W), .CHUNK(chunk_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .A         (a_in),
      .B         (b_in),
      .CIN       (cin_in),
      .SUB       (sub_in),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .S         (s_w[g]),
      .C         (c_w[g]),
      .V         (v_w[g]),
      .dbg_state (dbg_w[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];   // {C, V, S}

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the mathematical values.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ur;
    int sr;
    logic c;
    logic v;
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      c  = (ur > 65535);
    end
    v = (sr > 32767) || (sr < -32768);
    return {c, v, ur[W-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_idle();
    for (int i = 0; i < 40; i++) begin
      if (&in_ready_w) return;
      tick();
    end
    check("idle_timeout", 32'(in_ready_w), 32'hF);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // Runs one operation with out_ready=1 and checks every instance: out_valid
  // stays low until exactly NCH cycles after accept, the result is correct on
  // that cycle, and in_ready returns on the cycle after the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W+1:0] exp, input string tag);
    logic [W+1:0] e;
    wait_all_idle();
    exp_q.push_back(exp);
    out_ready = 1'b1;
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    in_valid = 1'b1;
    tick();  // accept edge
    in_valid = 1'b0;
    // Operand changes after accept must not disturb the result.
    a_in = W'($urandom); b_in = W'($urandom);
    cin_in = 1'($urandom); sub_in = 1'($urandom);
    e = exp_q[0];
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        if (cyc < nch_of(g)) begin
          check($sformatf("%s_early_valid_i%0d", tag, g), 32'(out_valid_w[g]), 32'd0);
        end else if (cyc == nch_of(g)) begin
          check($sformatf("%s_valid_i%0d", tag, g), 32'(out_valid_w[g]), 32'd1);
          check($sformatf("%s_s_i%0d", tag, g), 32'(s_w[g]), 32'(e[W-1:0]));
          check($sformatf("%s_c_i%0d", tag, g), 32'(c_w[g]), 32'(e[W+1]));
          check($sformatf("%s_v_i%0d", tag, g), 32'(v_w[g]), 32'(e[W]));
          check($sformatf("%s_busy_ready_i%0d", tag, g), 32'(in_ready_w[g]), 32'd0);
        end else if (cyc == nch_of(g) + 1) begin
          check($sformatf("%s_post_ready_i%0d", tag, g), 32'(in_ready_w[g]), 32'd1);
          check($sformatf("%s_post_valid_i%0d", tag, g), 32'(out_valid_w[g]), 32'd0);
          check($sformatf("%s_s_hold_i%0d", tag, g), 32'(s_w[g]), 32'(e[W-1:0]));
        end
      end
      // Only the cycle after accept sees a stray in_valid. No instance is
      // IDLE on the next edge, so the pulse must be ignored.
      in_valid = (cyc == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    void'(exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    //         a         b         cin   sub   s         c     v
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid_w), 32'd0);
    check("rst_c", 32'(c_w), 32'd0);
    check("rst_v", 32'(v_w), 32'd0);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_s_i%0d", g), 32'(s_w[g]), 32'd0);
      check($sformatf("rst_state_i%0d", g), 32'(dbg_w[g]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready_w), 32'hF);

    // Table vectors. The first one is accepted on the first edge after reset.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
             {tbl[i].c, tbl[i].v, tbl[i].s}, $sformatf("tbl%0d", i));
    end

    // Backpressure: the CHUNK=4 instance holds its result for 3 cycles while
    // in_valid pulses.
    wait_all_idle();
    out_ready = 1'b0;
    a_in = 16'h1234; b_in = 16'h4321; cin_in = 1'b1; sub_in = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_valid", 32'(out_valid_w[1]), 32'd1);
    check("bp_s", 32'(s_w[1]), 32'h5556);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a_in = W'($urandom); b_in = W'($urandom);
      tick();
      check($sformatf("bp_hold_valid%0d", k), 32'(out_valid_w[1]), 32'd1);
      check($sformatf("bp_hold_s%0d", k), 32'(s_w[1]), 32'h5556);
      check($sformatf("bp_hold_cv%0d", k), 32'({c_w[1], v_w[1]}), 32'd0);
      check($sformatf("bp_in_ready%0d", k), 32'(in_ready_w), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();  // result handshake edge for instance 1
    check("bp_release_valid", 32'(out_valid_w[1]), 32'd0);
    check("bp_release_ready", 32'(in_ready_w[1]), 32'd1);
    check("bp_release_s", 32'(s_w[1]), 32'h5556);
    wait_all_idle();

    // Reset after 2 chunks of the CHUNK=4 instance.
    a_in = 16'hFFFF; b_in = 16'h0001; cin_in = 1'b0; sub_in = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid_w), 32'd0);
    check("mid_rst_s", 32'(s_w[1]), 32'd0);
    check("mid_rst_c", 32'(c_w), 32'd0);
    check("mid_rst_v", 32'(v_w), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready_w), 32'hF);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 18'({1'b0, 1'b0, 16'h5556}), "after_rst");

    // Random operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      rc = 1'($urandom);
      rs = 1'($urandom);
      e  = ref_model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, e, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
